// File: rtl/count_ctrl.sv
// Command-driven controller for a free-running up-counter with a programmable
// terminal limit, periodic/one-shot modes and a valid/ready terminal-event output.
module count_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [2:0]       i_cmd_op,
  input  logic [WIDTH-1:0] i_cmd_data,
  output logic [WIDTH-1:0] o_count,
  output logic [WIDTH-1:0] o_limit,
  output logic             o_busy,
  output logic             o_evt_valid,
  input  logic             i_evt_ready,
  output logic             o_overrun
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN_PERIODIC,
    ST_RUN_ONESHOT,
    ST_DONE
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP            = 3'd0,
    OP_START_PERIODIC = 3'd1,
    OP_START_ONESHOT  = 3'd2,
    OP_STOP           = 3'd3,
    OP_LOAD_COUNT     = 3'd4,
    OP_LOAD_LIMIT     = 3'd5,
    OP_CLEAR          = 3'd6,
    OP_RSVD           = 3'd7
  } op_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             evt_q, evt_d;
  logic             ovr_q, ovr_d;

  logic running;
  logic hit;
  logic cmd_ready;
  logic accept;
  op_t  op;

  always_comb begin
    op        = op_t'(i_cmd_op);
    running   = (state_q == ST_RUN_PERIODIC) || (state_q == ST_RUN_ONESHOT);
    hit       = running && (count_q == limit_q);
    // Host is held off until a one-shot completion event has been consumed.
    cmd_ready = !((state_q == ST_DONE) && evt_q);
    accept    = i_cmd_valid && cmd_ready;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      limit_q <= '1;
      evt_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      limit_q <= limit_d;
      evt_q   <= evt_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    limit_d = limit_q;
    evt_d   = evt_q;
    ovr_d   = ovr_q;

    // Free-running datapath first; an accepted command below overrides it,
    // so STOP freezes the count at whatever value this step produced.
    if (running) begin
      if (hit) begin
        if (state_q == ST_RUN_PERIODIC) begin
          count_d = '0;
        end else begin
          state_d = ST_DONE;
        end
      end else begin
        count_d = count_q + 1'b1;
      end
    end

    if (hit) begin
      evt_d = 1'b1;
      if (evt_q && !i_evt_ready) begin
        ovr_d = 1'b1;
      end
    end else if (i_evt_ready) begin
      evt_d = 1'b0;
    end

    if (accept) begin
      case (op)
        OP_START_PERIODIC: state_d = ST_RUN_PERIODIC;
        OP_START_ONESHOT:  state_d = ST_RUN_ONESHOT;
        OP_STOP: begin
          if (running) begin
            state_d = ST_IDLE;
          end
        end
        OP_LOAD_COUNT:     count_d = i_cmd_data;
        OP_LOAD_LIMIT:     limit_d = i_cmd_data;
        OP_CLEAR: begin
          state_d = ST_IDLE;
          count_d = '0;
          evt_d   = 1'b0;
          ovr_d   = 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign o_cmd_ready = cmd_ready;
  assign o_count     = count_q;
  assign o_limit     = limit_q;
  assign o_busy      = running;
  assign o_evt_valid = evt_q;
  assign o_overrun   = ovr_q;

endmodule

// File: tb/tb_count_ctrl.sv
// Directed-vector bench for count_ctrl: stimulus pushes hand-computed post-edge
// snapshots into a queue, an independent monitor pops and compares after each edge.
module tb_count_ctrl;

  localparam logic [2:0] NOP = 3'd0, SP = 3'd1, SO = 3'd2, STP = 3'd3,
                         LC  = 3'd4, LL = 3'd5, CLR = 3'd6, RSV = 3'd7;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_data;
  logic [3:0] count;
  logic [3:0] limit;
  logic       busy;
  logic       evt_valid;
  logic       evt_ready;
  logic       overrun;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [3:0] c;
    logic [3:0] l;
    logic       b;
    logic       e;
    logic       o;
    logic       r;
    string      nm;
  } exp_t;

  exp_t q[$];
  exp_t cur;

  count_ctrl #(.WIDTH(4)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_cmd_valid (cmd_valid),
    .o_cmd_ready (cmd_ready),
    .i_cmd_op    (cmd_op),
    .i_cmd_data  (cmd_data),
    .o_count     (count),
    .o_limit     (limit),
    .o_busy      (busy),
    .o_evt_valid (evt_valid),
    .i_evt_ready (evt_ready),
    .o_overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic compare(input exp_t x);
    checks++;
    if ({count, limit, busy, evt_valid, overrun, cmd_ready} === {x.c, x.l, x.b, x.e, x.o, x.r}) begin
      passes++;
    end else begin
      $display("FAIL %s: got cnt=%0d lim=%0d busy=%0b evt=%0b ovr=%0b rdy=%0b, required cnt=%0d lim=%0d busy=%0b evt=%0b ovr=%0b rdy=%0b",
               x.nm, count, limit, busy, evt_valid, overrun, cmd_ready,
               x.c, x.l, x.b, x.e, x.o, x.r);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      cur = q.pop_front();
      compare(cur);
    end
  end

  task automatic step(input bit v, input logic [2:0] op, input logic [3:0] d, input bit rdy,
                      input logic [3:0] ec, input logic [3:0] el, input bit eb, input bit ev,
                      input bit eo, input bit er, input string nm);
    exp_t x;
    @(negedge clk);
    cmd_valid = v;
    cmd_op    = op;
    cmd_data  = d;
    evt_ready = rdy;
    x.c = ec; x.l = el; x.b = eb; x.e = ev; x.o = eo; x.r = er; x.nm = nm;
    q.push_back(x);
  endtask

  task automatic check_reset_values(input string nm);
    exp_t x;
    x.c = 4'd0; x.l = 4'hF; x.b = 1'b0; x.e = 1'b0; x.o = 1'b0; x.r = 1'b1; x.nm = nm;
    compare(x);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = NOP; cmd_data = '0; evt_ready = 1'b0;
    #2 rst = 1'b0;
    #1 check_reset_values("reset_initial");
    @(negedge clk);
    rst = 1'b1;

    // Periodic, limit 5, consumer always ready
    step(1, LL,  4'd5, 1, 4'd0, 4'd5, 0, 0, 0, 1, "t1_load_limit");
    step(1, SP,  4'd0, 1, 4'd0, 4'd5, 1, 0, 0, 1, "t1_start");
    for (int r = 0; r < 2; r++) begin
      for (int i = 1; i <= 5; i++)
        step(0, NOP, 4'd0, 1, 4'(i), 4'd5, 1, 0, 0, 1, "t1_count");
      step(0, NOP, 4'd0, 1, 4'd0, 4'd5, 1, 1, 0, 1, "t1_wrap_evt");
    end
    step(1, STP, 4'd0, 1, 4'd1, 4'd5, 0, 0, 0, 1, "t1_stop");
    step(0, NOP, 4'd0, 1, 4'd1, 4'd5, 0, 0, 0, 1, "t1_idle_hold");
    step(1, CLR, 4'd0, 1, 4'd0, 4'd5, 0, 0, 0, 1, "t1_clear");

    // One-shot, limit 3, consumer stalled
    step(1, LL,  4'd3, 0, 4'd0, 4'd3, 0, 0, 0, 1, "t2_load_limit");
    step(1, SO,  4'd0, 0, 4'd0, 4'd3, 1, 0, 0, 1, "t2_start");
    for (int i = 1; i <= 3; i++)
      step(0, NOP, 4'd0, 0, 4'(i), 4'd3, 1, 0, 0, 1, "t2_count");
    step(0, NOP, 4'd0, 0, 4'd3, 4'd3, 0, 1, 0, 0, "t2_done");
    step(0, NOP, 4'd0, 0, 4'd3, 4'd3, 0, 1, 0, 0, "t2_done_hold");
    step(1, CLR, 4'd0, 0, 4'd3, 4'd3, 0, 1, 0, 0, "t2_cmd_stalled");
    step(0, NOP, 4'd0, 1, 4'd3, 4'd3, 0, 0, 0, 1, "t2_evt_taken");
    step(1, SP,  4'd0, 1, 4'd3, 4'd3, 1, 0, 0, 1, "t2_restart");
    step(0, NOP, 4'd0, 1, 4'd0, 4'd3, 1, 1, 0, 1, "t2_restart_hit");
    step(1, CLR, 4'd0, 1, 4'd0, 4'd3, 0, 0, 0, 1, "t2_clear");

    // Periodic, limit 2, overrun
    step(1, LL,  4'd2, 0, 4'd0, 4'd2, 0, 0, 0, 1, "t3_load_limit");
    step(1, SP,  4'd0, 0, 4'd0, 4'd2, 1, 0, 0, 1, "t3_start");
    step(0, NOP, 4'd0, 0, 4'd1, 4'd2, 1, 0, 0, 1, "t3_c1");
    step(0, NOP, 4'd0, 0, 4'd2, 4'd2, 1, 0, 0, 1, "t3_c2");
    step(0, NOP, 4'd0, 0, 4'd0, 4'd2, 1, 1, 0, 1, "t3_first_hit");
    step(0, NOP, 4'd0, 0, 4'd1, 4'd2, 1, 1, 0, 1, "t3_pending1");
    step(0, NOP, 4'd0, 0, 4'd2, 4'd2, 1, 1, 0, 1, "t3_pending2");
    step(0, NOP, 4'd0, 0, 4'd0, 4'd2, 1, 1, 1, 1, "t3_overrun");
    step(0, NOP, 4'd0, 1, 4'd1, 4'd2, 1, 0, 1, 1, "t3_overrun_sticky");
    step(1, CLR, 4'd0, 1, 4'd0, 4'd2, 0, 0, 0, 1, "t3_clear");

    // Loaded count above limit wraps before reaching limit
    step(1, LL,  4'd7,  1, 4'd0,  4'd7, 0, 0, 0, 1, "t4_load_limit");
    step(1, SP,  4'd0,  1, 4'd0,  4'd7, 1, 0, 0, 1, "t4_start");
    step(1, LC,  4'd12, 1, 4'd12, 4'd7, 1, 0, 0, 1, "t4_load_count");
    for (int i = 13; i <= 23; i++)
      step(0, NOP, 4'd0, 1, 4'(i), 4'd7, 1, 0, 0, 1, "t4_count_wrap");
    step(0, NOP, 4'd0, 1, 4'd0, 4'd7, 1, 1, 0, 1, "t4_hit");
    step(0, NOP, 4'd0, 1, 4'd1, 4'd7, 1, 0, 0, 1, "t4_after_hit");
    step(1, STP, 4'd0, 1, 4'd2, 4'd7, 0, 0, 0, 1, "t4_stop");

    // STOP / CLEAR on the terminal edge
    step(1, LL,  4'd2, 1, 4'd2, 4'd2, 0, 0, 0, 1, "t5_load_limit");
    step(1, SP,  4'd0, 1, 4'd2, 4'd2, 1, 0, 0, 1, "t5_start");
    step(1, STP, 4'd0, 1, 4'd0, 4'd2, 0, 1, 0, 1, "t5_stop_on_hit");
    step(0, NOP, 4'd0, 1, 4'd0, 4'd2, 0, 0, 0, 1, "t5_evt_taken");
    step(1, SP,  4'd0, 1, 4'd0, 4'd2, 1, 0, 0, 1, "t5_restart");
    step(0, NOP, 4'd0, 1, 4'd1, 4'd2, 1, 0, 0, 1, "t5_c1");
    step(0, NOP, 4'd0, 1, 4'd2, 4'd2, 1, 0, 0, 1, "t5_c2");
    step(1, CLR, 4'd0, 1, 4'd0, 4'd2, 0, 0, 0, 1, "t5_clear_on_hit");
    step(0, NOP, 4'd0, 1, 4'd0, 4'd2, 0, 0, 0, 1, "t5_no_evt");

    // Limit 0: hit every cycle; hit + accept on one edge keeps valid without overrun
    step(1, LL,  4'd0, 1, 4'd0, 4'd0, 0, 0, 0, 1, "t6_load_limit0");
    step(1, SP,  4'd0, 1, 4'd0, 4'd0, 1, 0, 0, 1, "t6_start");
    step(0, NOP, 4'd0, 1, 4'd0, 4'd0, 1, 1, 0, 1, "t6_hit");
    step(0, NOP, 4'd0, 1, 4'd0, 4'd0, 1, 1, 0, 1, "t6_hit_and_accept");
    step(0, NOP, 4'd0, 0, 4'd0, 4'd0, 1, 1, 1, 1, "t6_overrun");

    // Asynchronous reset mid-run with an event pending
    @(posedge clk);
    #3 rst = 1'b0;
    #1 check_reset_values("reset_async_midrun");
    @(negedge clk);
    rst = 1'b1;
    step(1, RSV, 4'd9, 0, 4'd0, 4'hF, 0, 0, 0, 1, "reserved_op_nop");
    step(1, LC,  4'd9, 0, 4'd9, 4'hF, 0, 0, 0, 1, "load_count_idle");

    @(posedge clk);
    #2;
    checks++;
    if (q.size() == 0) passes++;
    else $display("FAIL scoreboard_drain: got %0d pending entries, required 0", q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/count_ctrl.md
Name: count_ctrl

Overview:
- Command-driven controller that sequences a free-running up-counter datapath: start/stop, load count, program a terminal limit, clear.
- Supports periodic (wrap at limit) and one-shot (stop at limit) modes.
- Each terminal hit is reported to a consumer over a valid/ready event handshake; a sticky overrun flag flags lost events.
- Sits between the host command interface and counter-based timing logic.

Parameters:
- WIDTH, 4: counter and limit width in bits.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  asynchronous, active-low reset.
- i_cmd_valid  input  1  command valid.
- o_cmd_ready  output  1  command ready; a command is accepted on an edge where valid & ready.
- i_cmd_op  input  3  opcode:
  - 0 NOP
  - 1 START_PERIODIC
  - 2 START_ONESHOT
  - 3 STOP
  - 4 LOAD_COUNT
  - 5 LOAD_LIMIT
  - 6 CLEAR
  - 7 reserved, treated as NOP
- i_cmd_data  input  WIDTH  operand for LOAD_COUNT / LOAD_LIMIT.
- o_count  output  WIDTH  current count register.
- o_limit  output  WIDTH  current limit register.
- o_busy  output  1  high in RUN_PERIODIC or RUN_ONESHOT.
- o_evt_valid  output  1  terminal event pending.
- i_evt_ready  input  1  consumer accepts the event.
- o_overrun  output  1  sticky: a terminal hit occurred while the previous event was still pending.

Behaviour:
- Reset values (immediate on i_rst low, no clock needed):
  - state IDLE
  - o_count 0
  - o_limit all-ones
  - o_evt_valid 0
  - o_overrun 0
  - o_busy 0
- States:
  - IDLE: count holds.
    - START_PERIODIC -> RUN_PERIODIC.
    - START_ONESHOT -> RUN_ONESHOT.
  - RUN_PERIODIC: count increments by 1 each cycle, modulo 2^WIDTH.
    - Terminal hit when count_q == limit_q: next count = 0, event raised, state stays.
  - RUN_ONESHOT: increments as above.
    - On terminal hit: count holds at limit, event raised, -> DONE.
  - DONE: count holds. START_* restarts from the current count. CLEAR -> IDLE.
- STOP in any RUN state -> IDLE, count frozen at the value it would otherwise have taken.
- Latency: START accepted at edge N sets o_busy after N; first increment occurs at edge N+1.
- LOAD_COUNT / LOAD_LIMIT:
  - Write the register at the accepting edge; allowed in any state; the state is unchanged.
  - A loaded count overrides the increment and the wrap-to-0 on that edge.
  - A loaded count above the limit counts up, wraps modulo 2^WIDTH, then reaches the limit.
  - Limit 0 in RUN_PERIODIC gives a terminal hit every cycle.
- CLEAR: count -> 0, state -> IDLE, o_evt_valid -> 0, o_overrun -> 0; o_limit is unchanged.
- Terminal detection uses pre-edge count_q/limit_q and state. A hit on the same edge as an accepted command still raises its event; the command's register/state effect then takes priority. Exception: CLEAR also discards that event.
- Event handshake:
  - o_evt_valid sets on a terminal hit and clears on an edge with i_evt_ready & !new hit.
  - Hit while valid & !i_evt_ready -> o_overrun set, valid stays 1.
  - Hit and accept on the same edge -> valid stays 1, no overrun.
  - i_evt_ready while valid is 0 is ignored.
- o_cmd_ready = 1 except in DONE while o_evt_valid = 1. The controller stalls the host until the one-shot event is consumed.
- Reset asserted mid-run aborts immediately to reset values; commands and events in flight are lost.

Test Plan:
- Reset, LOAD_LIMIT 5, START_PERIODIC, hold i_evt_ready=1 -> o_count 0,1,2,3,4,5,0,1…; o_evt_valid pulses one cycle after each count==5 edge; o_overrun stays 0.
- LOAD_LIMIT 3, START_ONESHOT, i_evt_ready=0 -> count 0..3 then holds 3, state DONE, o_cmd_ready=0. Assert i_evt_ready -> o_evt_valid 0, then o_cmd_ready 1.
- Periodic with limit 2, i_evt_ready=0 -> second hit sets o_overrun=1. CLEAR -> o_overrun 0, o_evt_valid 0, o_count 0, o_limit still 2.
- Limit 7, LOAD_COUNT 12 (WIDTH 4) while running -> count 12..15,0..7, event at 7; 15 wraps to 0 with no event.
- Accept STOP on the edge where count==limit in periodic mode -> event raised, count 0, o_busy 0. Repeat with CLEAR on that edge -> no event.
- Drive i_rst low asynchronously mid-run with o_evt_valid=1 -> all outputs return to reset values before the next clock edge.
